// File: rtl/mem_subsystem.sv
// mem_subsystem: word-addressed RAM plus switch/LED I/O registers behind a wait-state FSM.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   mem_cmd    2'b00 none, 2'b01 read, 2'b10 write, 2'b11 illegal (ignored)
//   mem_addr   word address
//   write_data store data, sampled with the command
//   read_data  registered load result, held until the next completed read
//   mem_ready  one-cycle pulse when an access has completed
//   sw         board switches, readable at 0x100
//   leds       registered board LEDs, read/write at 0x140
//   bus_err    only when MEM_BUS_ERR_EN is defined: pulses on unmapped access,
//              write to SW, or one cycle after an illegal command in IDLE
//
// Optional feature macro: MEM_BUS_ERR_EN
module mem_subsystem #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int RAM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    input  logic [7:0]        sw,
    output logic [7:0]        leds
`ifdef MEM_BUS_ERR_EN
    ,
    output logic              bus_err
`endif
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              a_wr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic              ram_hit, sw_hit, led_hit, accept, access;
    logic [DATA_W-1:0] rd_mux;
    // The full-width compare keeps 0x100 and above out of RAM even at 256 words.
    assign ram_hit   = a_addr < ADDR_W'(RAM_WORDS);
    assign sw_hit    = a_addr == ADDR_W'(9'h100);
    assign led_hit   = a_addr == ADDR_W'(9'h140);
    assign accept    = state == IDLE && (mem_cmd == 2'b01 || mem_cmd == 2'b10);
    assign access    = state == BUSY && cnt == 4'd0;
    assign mem_ready = state == DONE;
    assign rd_mux    = ram_hit ? ram[a_addr[7:0]] : sw_hit ? DATA_W'(sw) : led_hit ? DATA_W'(leds) : '0;
    always_ff @(posedge clk) begin
        if (accept) begin
            a_wr   <= mem_cmd[1];
            a_addr <= mem_addr;
            a_data <= write_data;
        end
    end
    // RAM is never cleared; reset only blocks a pending write from committing.
    always_ff @(posedge clk) begin
        if (!reset && access && a_wr && ram_hit) ram[a_addr[7:0]] <= a_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
            leds      <= '0;
        end else begin
            state <= accept ? BUSY : access ? DONE : state == BUSY ? BUSY : IDLE;
            cnt   <= accept ? 4'(WAIT_STATES) : (state == BUSY && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            if (access && !a_wr) read_data <= rd_mux;
            if (access && a_wr && led_hit) leds <= a_data[7:0];
        end
    end
`ifdef MEM_BUS_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) bus_err <= 1'b0;
        else bus_err <= (state == IDLE && mem_cmd == 2'b11) ||
                        (access && (a_wr ? !(ram_hit || led_hit) : !(ram_hit || sw_hit || led_hit)));
    end
`endif
endmodule

// File: tb/tb_mem_subsystem.sv
// tb_mem_subsystem: checks two mem_subsystem instances (0 and 3 wait states) against a cycle-scheduled model.
module tb_mem_subsystem;
    logic        clk = 1'b0;
    logic        rst [2];
    logic [1:0]  cmd [2];
    logic [8:0]  addr [2];
    logic [15:0] wd [2];
    logic [15:0] rd [2];
    logic        rdy [2];
    logic [7:0]  led [2];
    logic [7:0]  sw;
    logic        berr [2];
    int          tests = 0, fails = 0;
    bit          chk_en = 0;
    always #5 clk = ~clk;

    mem_subsystem #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(rst[0]), .mem_cmd(cmd[0]), .mem_addr(addr[0]), .write_data(wd[0]),
        .read_data(rd[0]), .mem_ready(rdy[0]), .sw(sw), .leds(led[0])
`ifdef MEM_BUS_ERR_EN
        , .bus_err(berr[0])
`endif
    );
    mem_subsystem #(.WAIT_STATES(3)) u3 (
        .clk(clk), .reset(rst[1]), .mem_cmd(cmd[1]), .mem_addr(addr[1]), .write_data(wd[1]),
        .read_data(rd[1]), .mem_ready(rdy[1]), .sw(sw), .leds(led[1])
`ifdef MEM_BUS_ERR_EN
        , .bus_err(berr[1])
`endif
    );
`ifndef MEM_BUS_ERR_EN
    assign berr[0] = 1'b0;
    assign berr[1] = 1'b0;
`endif

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Model: each accepted command is scheduled to take effect on a known cycle number.
    int          ws [2] = '{0, 3};
    int          cyc = 0;
    int          acc [2], busy_until [2], ill [2];
    bit          p_wr [2], merr [2];
    logic [8:0]  p_addr [2];
    logic [15:0] p_dat [2];
    logic [15:0] mram [2][256];
    logic [15:0] mrd [2];
    logic [7:0]  mled [2];
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                acc[k] = -10; busy_until[k] = -10; ill[k] = -10; mrd[k] = 0; mled[k] = 0;
            end else begin
                if (cyc == acc[k]) begin
                    merr[k] = 0;
                    if (p_wr[k]) begin
                        if (p_addr[k] < 256) mram[k][p_addr[k][7:0]] = p_dat[k];
                        else if (p_addr[k] == 9'h140) mled[k] = p_dat[k][7:0];
                        else merr[k] = 1;
                    end else begin
                        if (p_addr[k] < 256) mrd[k] = mram[k][p_addr[k][7:0]];
                        else if (p_addr[k] == 9'h100) mrd[k] = {8'h00, sw};
                        else if (p_addr[k] == 9'h140) mrd[k] = {8'h00, mled[k]};
                        else begin mrd[k] = 0; merr[k] = 1; end
                    end
                end
                if (cyc > busy_until[k]) begin
                    if (cmd[k] == 2'b01 || cmd[k] == 2'b10) begin
                        p_wr[k] = cmd[k] == 2'b10; p_addr[k] = addr[k]; p_dat[k] = wd[k];
                        acc[k] = cyc + 1 + ws[k]; busy_until[k] = acc[k] + 1;
                    end else if (cmd[k] == 2'b11) ill[k] = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("mem_ready", k, 32'(rdy[k]), 32'(cyc == acc[k]));
                chk("read_data", k, 32'(rd[k]), 32'(mrd[k]));
                chk("leds", k, 32'(led[k]), 32'(mled[k]));
`ifdef MEM_BUS_ERR_EN
                chk("bus_err", k, 32'(berr[k]), 32'((cyc == acc[k] && merr[k]) || cyc == ill[k]));
`endif
            end
        end
    end

    // Issue one command at a negedge and wait for completion; lat counts edges from
    // the command edge to the edge that samples mem_ready high.
    task automatic op(input int k, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                      input logic [8:0] a2, input int exp_lat);
        int n = 0;
        cmd[k] = c; addr[k] = a; wd[k] = d;
        @(negedge clk);
        cmd[k] = 2'b00; addr[k] = a2;
        while (!rdy[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", k, 32'(n + 1), 32'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1; cmd[k] = 0; addr[k] = 0; wd[k] = 0;
        end
        sw = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset read_data", 0, 32'(rd[0]), 32'h0);
        chk("reset read_data", 1, 32'(rd[1]), 32'h0);
        chk("reset mem_ready", 0, 32'(rdy[0]), 32'h0);
        chk("reset leds", 1, 32'(led[1]), 32'h0);
        rst[0] = 0; rst[1] = 0;
        @(negedge clk);
        op(0, 2'b10, 9'h005, 16'hABCD, 9'h005, 2);
        op(0, 2'b01, 9'h005, 16'h0000, 9'h005, 2);
        chk("ram read", 0, 32'(rd[0]), 32'h0000ABCD);
        op(1, 2'b10, 9'h005, 16'hABCD, 9'h005, 5);
        op(1, 2'b10, 9'h006, 16'h6666, 9'h006, 5);
        op(1, 2'b10, 9'h010, 16'h2222, 9'h010, 5);
        op(1, 2'b01, 9'h005, 16'h0000, 9'h006, 5);
        chk("addr change ignored", 1, 32'(rd[1]), 32'h0000ABCD);
        sw = 8'h5A;
        op(0, 2'b01, 9'h100, 16'h0000, 9'h100, 2);
        chk("sw read", 0, 32'(rd[0]), 32'h0000005A);
        op(0, 2'b10, 9'h140, 16'h12C3, 9'h140, 2);
        chk("led write", 0, 32'(led[0]), 32'h000000C3);
        op(0, 2'b01, 9'h140, 16'h0000, 9'h140, 2);
        chk("led read", 0, 32'(rd[0]), 32'h000000C3);
        op(0, 2'b10, 9'h100, 16'hFFFF, 9'h100, 2);
        chk("sw write dropped", 0, 32'(led[0]), 32'h000000C3);
        op(0, 2'b01, 9'h1F0, 16'h0000, 9'h1F0, 2);
        chk("unmapped read", 0, 32'(rd[0]), 32'h0);
        op(0, 2'b01, 9'h100, 16'h0000, 9'h100, 2);
        chk("0x100 not RAM", 0, 32'(rd[0]), 32'h0000005A);
        cmd[1] = 2'b10; addr[1] = 9'h010; wd[1] = 16'h1111;
        @(negedge clk);
        cmd[1] = 2'b00;
        @(negedge clk);
        rst[1] = 1;
        @(negedge clk);
        rst[1] = 0;
        repeat (4) begin
            chk("no ready after abort", 1, 32'(rdy[1]), 32'h0);
            @(negedge clk);
        end
        op(1, 2'b01, 9'h010, 16'h0000, 9'h010, 5);
        chk("aborted write", 1, 32'(rd[1]), 32'h00002222);
        cmd[0] = 2'b11; cmd[1] = 2'b11;
        @(negedge clk);
        cmd[0] = 2'b00; cmd[1] = 2'b00;
        repeat (3) begin
            chk("illegal no ready", 0, 32'(rdy[0]), 32'h0);
            @(negedge clk);
        end
        op(0, 2'b01, 9'h005, 16'h0000, 9'h005, 2);
        chk("read after illegal", 0, 32'(rd[0]), 32'h0000ABCD);
        op(1, 2'b01, 9'h006, 16'h0000, 9'h006, 5);
        chk("read after illegal", 1, 32'(rd[1]), 32'h00006666);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_subsystem.md
Name: mem_subsystem

Overview:
- Downstream stage of the CPU. Consumes mem_cmd / mem_addr / write_data and returns read_data.
- Contains a word-addressed RAM plus two memory-mapped I/O registers: switch input and LED output.
- A small FSM provides configurable wait states and a one-cycle mem_ready completion pulse, so later CPU revisions can stall on slow memory.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 9, address width; must match the CPU mem_addr
- RAM_WORDS, 256, RAM depth; RAM decodes at addresses 0x000..RAM_WORDS-1 (must be <= 256)
- WAIT_STATES, 0, extra cycles inserted before each access commits (0..15)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_cmd  in  2  2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 illegal (treated as MNONE)
- mem_addr  in  ADDR_W  word address
- write_data  in  DATA_W  store data; sampled with the command
- read_data  out  DATA_W  load result; registered
- mem_ready  out  1  one-cycle pulse: access completed
- sw  in  8  board switches
- leds  out  8  board LEDs; registered

Behaviour:
- Reset (synchronous, one edge): state=IDLE, read_data=0, mem_ready=0, leds=0, wait counter=0. RAM contents are not cleared.
- Address map:
  - 0x000..RAM_WORDS-1: RAM
  - 0x100: SW (read-only); reads return {8'b0, sw}
  - 0x140: LED; writes set leds <= write_data[7:0], reads return {8'b0, leds}
  - All other addresses: unmapped
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_cmd in {MREAD, MWRITE}: latch cmd, addr and write_data; load counter=WAIT_STATES; go to BUSY.
  - Otherwise: stay in IDLE.
- BUSY:
  - counter!=0: decrement and stay.
  - counter==0: perform the access at this edge, then go to DONE.
    - Write: RAM, or LED register when addr=0x140.
    - Read: read_data <= selected source.
- DONE: mem_ready=1 for exactly this cycle; unconditionally return to IDLE. A new command is only accepted in IDLE.
- Latency: command sampled at edge N → access at edge N+1+WAIT_STATES → mem_ready high during the cycle after that edge.
- While the FSM is in BUSY or DONE, input changes are ignored; the latched values are used.
- read_data holds its value until the next completed read. Writes do not change read_data.
- Writes to SW or to unmapped addresses are dropped. Reads from unmapped addresses return 0. mem_ready still pulses in both cases.
- Illegal cmd 2'b11 never leaves IDLE.
- Reset asserted in BUSY or DONE: FSM returns to IDLE. A pending write is discarded and RAM is unchanged. No mem_ready is issued.
- A mem_addr of 0x100 must not alias RAM even if RAM_WORDS=256. RAM decode requires addr[8]==0.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined:
  - Adds output port bus_err (1 bit), reset value 0.
  - bus_err pulses together with mem_ready when the completed access targeted an unmapped address or was a write to SW.
  - bus_err also pulses for one cycle, one cycle after an illegal cmd 2'b11 is sampled in IDLE. No mem_ready accompanies it and the FSM stays in IDLE.
- Undefined: no bus_err port; behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=0: MWRITE addr 0x005 data 16'hABCD, then MREAD 0x005 → each mem_ready exactly 2 cycles after the command edge; read_data=16'hABCD.
- WAIT_STATES=3: MREAD 0x005 → mem_ready 5 cycles after the command edge; read_data unchanged before the access edge.
- sw=8'h5A, MREAD 0x100 → read_data=16'h005A. MWRITE 0x140 data 16'h12C3 → leds=8'hC3. Then MREAD 0x140 → 16'h00C3.
- MWRITE 0x100 data 16'hFFFF, then MREAD 0x1F0 → leds unchanged, read_data=0. With MEM_BUS_ERR_EN, bus_err pulses with each mem_ready.
- WAIT_STATES=3: MWRITE 0x010 data 16'h1111, assert reset during BUSY → FSM in IDLE, no mem_ready; MREAD 0x010 returns the prior contents, not 16'h1111.
- Change mem_addr from 0x005 to 0x006 while BUSY on MREAD 0x005 → read_data returns RAM[0x005]. Then mem_cmd=2'b11 → FSM stays IDLE, no mem_ready.
